// File: rtl/data_memory_unit.sv
// MEM-stage data memory: lane-placed stores, 1-cycle loads, independent debug read port,
// and a sequential zero-clear of the array after every reset.
module data_memory_unit #(
  parameter int unsigned        NB_DATA       = 32,
  parameter int unsigned        NB_ADDR       = 32,
  parameter int unsigned        NB_TYPE       = 3,
  parameter int unsigned        DEPTH         = 256,
  parameter int unsigned        NB_IDX        = 8,
  parameter logic [NB_TYPE-1:0] BYTE_WORD     = NB_TYPE'(0),
  parameter logic [NB_TYPE-1:0] HALF_WORD     = NB_TYPE'(1),
  parameter logic [NB_TYPE-1:0] COMPLETE_WORD = NB_TYPE'(2)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_write,
  input  logic               i_mem_read,
  input  logic [NB_TYPE-1:0] i_word_size,
  input  logic [NB_ADDR-1:0] i_address,
  input  logic [NB_DATA-1:0] i_data_in,
  output logic [NB_DATA-1:0] o_data_out,
  output logic               o_read_valid,
  output logic               o_misaligned,
  output logic               o_ready,
  input  logic               i_debug_read,
  input  logic [NB_IDX-1:0]  i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_debug_valid
);

  localparam int unsigned NB_LANE = 4;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [NB_IDX-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  mem [DEPTH];

  logic [NB_IDX-1:0]   idx_c;
  logic [1:0]          lane_c;
  logic                run_c;
  logic                rd_c;
  logic                dbg_rd_c;
  logic                wr_en_c;
  logic [NB_LANE-1:0]  be_c;
  logic [NB_IDX-1:0]   wr_idx_c;
  logic [NB_DATA-1:0]  wr_data_c;
  logic                misaligned_d;
  logic                unused_addr_c;

  assign idx_c         = i_address[NB_IDX+1:2];
  assign lane_c        = i_address[1:0];
  assign unused_addr_c = ^i_address[NB_ADDR-1:NB_IDX+2];
  assign run_c         = (state_q == RUN);
  assign rd_c          = run_c & i_mem_read;
  assign dbg_rd_c      = run_c & i_debug_read;

  // Next state, clear sequencing and store lane/enable decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_en_c      = 1'b0;
    be_c         = '0;
    wr_idx_c     = idx_c;
    wr_data_c    = '0;
    misaligned_d = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_en_c  = 1'b1;
        be_c     = '1;
        wr_idx_c = cnt_q;
        cnt_d    = cnt_q + NB_IDX'(1);
        if (cnt_q == NB_IDX'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_mem_write) begin
          // Undefined size codes fall through: no write and no misaligned flag
          case (i_word_size)
            BYTE_WORD: begin
              wr_en_c   = 1'b1;
              be_c      = NB_LANE'(1) << lane_c;
              wr_data_c = NB_DATA'({NB_LANE{i_data_in[7:0]}});
            end
            HALF_WORD: begin
              if (lane_c[0]) begin
                misaligned_d = 1'b1;
              end else begin
                wr_en_c   = 1'b1;
                be_c      = lane_c[1] ? 4'b1100 : 4'b0011;
                wr_data_c = NB_DATA'({2{i_data_in[15:0]}});
              end
            end
            COMPLETE_WORD: begin
              if (lane_c != 2'b00) begin
                misaligned_d = 1'b1;
              end else begin
                wr_en_c   = 1'b1;
                be_c      = '1;
                wr_data_c = i_data_in;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      o_ready      <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_ready      <= (state_d == RUN);
      o_misaligned <= misaligned_d;
    end
  end

  // Array has no reset; zeroing comes only from the CLEAR walk
  always_ff @(posedge i_clk) begin
    if (wr_en_c && !i_reset) begin
      for (int b = 0; b < NB_LANE; b++) begin
        if (be_c[b]) begin
          mem[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  // Registered read ports; same-edge stores land after the read, so reads see the old word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_out    <= '0;
      o_read_valid  <= 1'b0;
      o_debug_data  <= '0;
      o_debug_valid <= 1'b0;
    end else begin
      o_read_valid  <= rd_c;
      o_debug_valid <= dbg_rd_c;
      if (rd_c) begin
        o_data_out <= mem[idx_c];
      end
      if (dbg_rd_c) begin
        o_debug_data <= mem[i_debug_addr];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: vector table for stores/loads, hand sequences for
// clear timing, reset mid-clear and post-clear contents.
module tb_data_memory_unit;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_X = 3'd7;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write, mem_read, debug_read;
  logic [2:0]  word_size;
  logic [31:0] address, data_in;
  logic [7:0]  debug_addr;
  logic [31:0] data_out, debug_data;
  logic        read_valid, misaligned, ready, debug_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_unit dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_mem_write  (mem_write),
    .i_mem_read   (mem_read),
    .i_word_size  (word_size),
    .i_address    (address),
    .i_data_in    (data_in),
    .o_data_out   (data_out),
    .o_read_valid (read_valid),
    .o_misaligned (misaligned),
    .o_ready      (ready),
    .i_debug_read (debug_read),
    .i_debug_addr (debug_addr),
    .o_debug_data (debug_data),
    .o_debug_valid(debug_valid)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] din;
    logic        dbg;
    logic [7:0]  daddr;
    logic        exp_rv;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_dv;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [2:0] sz,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic dbg, input logic [7:0] daddr,
                     input logic erv, input logic [31:0] edata, input logic emis,
                     input logic edv, input logic [31:0] edbg);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sz = sz; v.addr = addr; v.din = din;
    v.dbg = dbg; v.daddr = daddr; v.exp_rv = erv; v.exp_data = edata;
    v.exp_mis = emis; v.exp_dv = edv; v.exp_dbg = edbg;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    mem_write = 1'b0; mem_read = 1'b0; debug_read = 1'b0;
    word_size = SZ_W; address = '0; data_in = '0; debug_addr = '0;
  endtask

  // Count edges from reset release until o_ready; flag any pulse seen while not ready
  task automatic clear_phase(input string name);
    int  n = 0;
    bit  spurious = 0;
    bit  seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (ready) begin
        seen = 1;
        idle_inputs();
        break;
      end
      if (read_valid || debug_valid || misaligned) spurious = 1;
    end
    chk({name, "_ready_seen"}, 32'(seen), 32'd1);
    chk({name, "_cycles"}, 32'(n), 32'(DEPTH));
    chk({name, "_no_pulse"}, 32'(spurious), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    add(0,0,SZ_W,32'h00,32'h0,        1,8'd5,  0,32'h0,0,        1,32'h0);
    add(0,0,SZ_W,32'h00,32'h0,        0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,0,SZ_W,32'h10,32'hDEADBEEF, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h10,32'h0,        0,8'd0,  1,32'hDEADBEEF,0, 0,32'h0);
    add(0,0,SZ_W,32'h00,32'h0,        0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,0,SZ_W,32'h10,32'h11223344, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,0,SZ_B,32'h13,32'h000000AB, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h10,32'h0,        0,8'd0,  1,32'hAB223344,0, 0,32'h0);
    add(1,0,SZ_W,32'h10,32'h11223344, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,0,SZ_B,32'h11,32'h000000AB, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h10,32'h0,        0,8'd0,  1,32'h1122AB44,0, 0,32'h0);
    add(1,0,SZ_W,32'h20,32'h11223344, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,0,SZ_H,32'h22,32'h0000CAFE, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h20,32'h0,        0,8'd0,  1,32'hCAFE3344,0, 0,32'h0);
    add(1,0,SZ_H,32'h23,32'h0000BEEF, 0,8'd0,  0,32'h0,1,        0,32'h0);
    add(0,0,SZ_W,32'h00,32'h0,        0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h20,32'h0,        0,8'd0,  1,32'hCAFE3344,0, 0,32'h0);
    add(1,0,SZ_W,32'h21,32'h99999999, 0,8'd0,  0,32'h0,1,        0,32'h0);
    add(0,1,SZ_W,32'h20,32'h0,        0,8'd0,  1,32'hCAFE3344,0, 0,32'h0);
    add(1,0,SZ_X,32'h20,32'hFFFFFFFF, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h20,32'h0,        0,8'd0,  1,32'hCAFE3344,0, 0,32'h0);
    add(1,0,SZ_W,32'h40,32'h00000011, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(1,1,SZ_W,32'h40,32'h00000055, 1,8'd16, 1,32'h00000011,0, 1,32'h00000011);
    add(0,1,SZ_W,32'h40,32'h0,        0,8'd0,  1,32'h00000055,0, 0,32'h0);
    add(0,1,SZ_W,32'h40,32'h0,        0,8'd0,  1,32'h00000055,0, 0,32'h0);
    add(1,0,SZ_B,32'h00,32'hFFFFFF7E, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h00,32'h0,        0,8'd0,  1,32'h0000007E,0, 0,32'h0);
    add(1,0,SZ_H,32'h00,32'hFFFF1234, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h00,32'h0,        0,8'd0,  1,32'h00001234,0, 0,32'h0);
    add(1,0,SZ_B,32'h02,32'hFFFFFF5A, 0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h00,32'h0,        0,8'd0,  1,32'h005A1234,0, 0,32'h0);
    add(1,0,SZ_W,32'h400,32'h12345678,0,8'd0,  0,32'h0,0,        0,32'h0);
    add(0,1,SZ_W,32'h00,32'h0,        1,8'd0,  1,32'h12345678,0, 1,32'h12345678);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out",    data_out,          32'h0);
    chk("rst_read_valid",  32'(read_valid),   32'h0);
    chk("rst_misaligned",  32'(misaligned),   32'h0);
    chk("rst_ready",       32'(ready),        32'h0);
    chk("rst_debug_data",  debug_data,        32'h0);
    chk("rst_debug_valid", 32'(debug_valid),  32'h0);

    @(negedge clk) rst = 1'b0;
    clear_phase("clear1");

    foreach (vecs[i]) begin
      @(negedge clk);
      mem_write  = vecs[i].wr;
      mem_read   = vecs[i].rd;
      word_size  = vecs[i].sz;
      address    = vecs[i].addr;
      data_in    = vecs[i].din;
      debug_read = vecs[i].dbg;
      debug_addr = vecs[i].daddr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'h1);
      chk($sformatf("v%0d_read_valid", i), 32'(read_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_data);
      chk($sformatf("v%0d_misaligned", i), 32'(misaligned), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_debug_valid", i), 32'(debug_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) chk($sformatf("v%0d_debug_data", i), debug_data, vecs[i].exp_dbg);
    end
    @(negedge clk) idle_inputs();

    // Reset from RUN, then reset again 100 cycles into the clear
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_ready", 32'(ready), 32'h0);
    chk("rst2_data_out", data_out, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    mem_write = 1'b1; mem_read = 1'b1; debug_read = 1'b1;
    word_size = SZ_W; address = 32'h10; data_in = 32'hFFFFFFFF; debug_addr = 8'd4;
    clear_phase("clear2");

    // Every word must read back as zero after the restarted clear
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      debug_read = 1'b1;
      debug_addr = 8'(i);
      @(posedge clk); #1;
      chk($sformatf("dump%0d_valid", i), 32'(debug_valid), 32'h1);
      chk($sformatf("dump%0d_data", i), debug_data, 32'h0);
    end
    @(negedge clk) idle_inputs();
    @(posedge clk); #1;
    chk("dump_end_valid", 32'(debug_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
